// File: rtl/battleship_board.sv
// battleship_board: game-state engine for a 5x5 single-cell Battleship game.
//
// Places the PC fleet from a free-running LFSR. Lets the player place a fleet
// and fire using a cursor moved by debounced button pulses. Alternates player
// and PC shots, and flags the winner. Both boards are presented as registered
// 5x5 matrices of 4-bit display codes, indexed [row][col], for the VGA top.
//
// Ports
//   clk                    system clock
//   rst                    synchronous, active-low reset
//   btn_up/down/left/right single-cycle cursor pulses
//   btn_sel                single-cycle place/fire pulse
//   matriz_player_final    player board codes (0 water, 1 ship, 2 miss, 3 hit, 4 cursor)
//   matriz_pc_final        PC board codes (PC ships are never shown)
//   game_state             current FSM state code (0..6)
//   player_won, pc_won     result flags, set in the terminal states
module battleship_board #(
  parameter int unsigned NUM_SHIPS = 3,            // 1..8
  parameter logic [7:0]  SEED      = 8'hA5,        // nonzero
  parameter int unsigned PC_DELAY  = 25_000_000    // >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  output logic [4:0][4:0][3:0] matriz_player_final,
  output logic [4:0][4:0][3:0] matriz_pc_final,
  output logic [2:0]           game_state,
  output logic                 player_won,
  output logic                 pc_won
);

  typedef enum logic [2:0] {
    S_SETUP_PC     = 3'd0,
    S_SETUP_PLAYER = 3'd1,
    S_PLAYER_TURN  = 3'd2,
    S_PC_WAIT      = 3'd3,
    S_PC_SHOOT     = 3'd4,
    S_WIN          = 3'd5,
    S_LOSE         = 3'd6
  } state_e;

  localparam logic [3:0]  NUM_SHIPS_C = 4'(NUM_SHIPS);
  localparam int unsigned DELAY_W     = (PC_DELAY > 1) ? $clog2(PC_DELAY) : 1;
  localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(PC_DELAY - 1);

  function automatic logic [4:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return 5'(row) * 5'd5 + 5'(col);
  endfunction

  state_e               state_q, state_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [24:0]          pc_ship_q, pc_ship_d, pc_shot_q, pc_shot_d;
  logic [24:0]          pl_ship_q, pl_ship_d, pl_shot_q, pl_shot_d;
  logic [2:0]           cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [3:0]           pl_hits_q, pl_hits_d, pc_hits_q, pc_hits_d;
  logic [3:0]           place_cnt_q, place_cnt_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [4:0][4:0][3:0] pl_disp_d, pc_disp_d;

  // LFSR candidate cell: row from bits [2:0], col from bits [5:3].
  logic       cand_valid;
  logic [4:0] cand_idx, cur_idx;
  assign cand_valid = (lfsr_q[2:0] < 3'd5) && (lfsr_q[5:3] < 3'd5);
  assign cand_idx   = cell_idx(lfsr_q[2:0], lfsr_q[5:3]);
  assign cur_idx    = cell_idx(cur_row_q, cur_col_q);

  // Saturating cursor move; one direction per cycle, up > down > left > right.
  logic [2:0] mv_row, mv_col;
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    mv_row = cur_row_q;
    mv_col = cur_col_q;
    if (btn_up) begin
      if (cur_row_q != 3'd0) mv_row = cur_row_q - 3'd1;
    end else if (btn_down) begin
      if (cur_row_q != 3'd4) mv_row = cur_row_q + 3'd1;
    end else if (btn_left) begin
      if (cur_col_q != 3'd0) mv_col = cur_col_q - 3'd1;
    end else if (btn_right) begin
      if (cur_col_q != 3'd4) mv_col = cur_col_q + 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pc_ship_d   = pc_ship_q;
    pc_shot_d   = pc_shot_q;
    pl_ship_d   = pl_ship_q;
    pl_shot_d   = pl_shot_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    pl_hits_d   = pl_hits_q;
    pc_hits_d   = pc_hits_q;
    place_cnt_d = place_cnt_q;
    delay_d     = delay_q;
    case (state_q)
      S_SETUP_PC: begin
        if (cand_valid && !pc_ship_q[cand_idx]) begin
          pc_ship_d[cand_idx] = 1'b1;
          place_cnt_d         = place_cnt_q + 4'd1;
          if (place_cnt_d == NUM_SHIPS_C) begin
            place_cnt_d = '0;
            state_d     = S_SETUP_PLAYER;
          end
        end
      end
      S_SETUP_PLAYER: begin
        if (btn_sel) begin
          // sel on an occupied cell is swallowed; it still wins over a move.
          if (!pl_ship_q[cur_idx]) begin
            pl_ship_d[cur_idx] = 1'b1;
            place_cnt_d        = place_cnt_q + 4'd1;
            if (place_cnt_d == NUM_SHIPS_C) begin
              place_cnt_d = '0;
              cur_row_d   = '0;
              cur_col_d   = '0;
              state_d     = S_PLAYER_TURN;
            end
          end
        end else begin
          cur_row_d = mv_row;
          cur_col_d = mv_col;
        end
      end
      S_PLAYER_TURN: begin
        if (btn_sel) begin
          if (!pc_shot_q[cur_idx]) begin
            pc_shot_d[cur_idx] = 1'b1;
            if (pc_ship_q[cur_idx]) pl_hits_d = pl_hits_q + 4'd1;
            state_d = (pl_hits_d == NUM_SHIPS_C) ? S_WIN : S_PC_WAIT;
          end
        end else begin
          cur_row_d = mv_row;
          cur_col_d = mv_col;
        end
      end
      S_PC_WAIT: begin
        if (delay_q == DELAY_LAST) begin
          delay_d = '0;
          state_d = S_PC_SHOOT;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end
      S_PC_SHOOT: begin
        if (cand_valid && !pl_shot_q[cand_idx]) begin
          pl_shot_d[cand_idx] = 1'b1;
          if (pl_ship_q[cand_idx]) pc_hits_d = pc_hits_q + 4'd1;
          state_d = (pc_hits_d == NUM_SHIPS_C) ? S_LOSE : S_PLAYER_TURN;
        end
      end
      default: ;  // WIN / LOSE hold until reset
    endcase
  end

  // Display overlay; the cursor code wins over anything underneath.
  always_comb begin
    pl_disp_d = '0;
    pc_disp_d = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        logic [4:0] i;
        logic       at_cur;
        i      = cell_idx(3'(r), 3'(c));
        at_cur = (cur_row_q == 3'(r)) && (cur_col_q == 3'(c));
        if (pl_shot_q[i])      pl_disp_d[r][c] = pl_ship_q[i] ? 4'd3 : 4'd2;
        else if (pl_ship_q[i]) pl_disp_d[r][c] = 4'd1;
        if (pc_shot_q[i])      pc_disp_d[r][c] = pc_ship_q[i] ? 4'd3 : 4'd2;
        if (at_cur && state_q == S_SETUP_PLAYER) pl_disp_d[r][c] = 4'd4;
        if (at_cur && state_q == S_PLAYER_TURN)  pc_disp_d[r][c] = 4'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the ship/shot maps are plain flops, not RAM, so reset clears them like any register.
      state_q             <= S_SETUP_PC;
      lfsr_q              <= SEED;
      pc_ship_q           <= '0;
      pc_shot_q           <= '0;
      pl_ship_q           <= '0;
      pl_shot_q           <= '0;
      cur_row_q           <= '0;
      cur_col_q           <= '0;
      pl_hits_q           <= '0;
      pc_hits_q           <= '0;
      place_cnt_q         <= '0;
      delay_q             <= '0;
      matriz_player_final <= '0;
      matriz_pc_final     <= '0;
      player_won          <= 1'b0;
      pc_won              <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q             <= state_d;
      lfsr_q              <= lfsr_d;
      pc_ship_q           <= pc_ship_d;
      pc_shot_q           <= pc_shot_d;
      pl_ship_q           <= pl_ship_d;
      pl_shot_q           <= pl_shot_d;
      cur_row_q           <= cur_row_d;
      cur_col_q           <= cur_col_d;
      pl_hits_q           <= pl_hits_d;
      pc_hits_q           <= pc_hits_d;
      place_cnt_q         <= place_cnt_d;
      delay_q             <= delay_d;
      matriz_player_final <= pl_disp_d;
      matriz_pc_final     <= pc_disp_d;
      player_won          <= (state_d == S_WIN);
      pc_won              <= (state_d == S_LOSE);
    end
  end

  assign game_state = state_q;

endmodule

// File: tb/tb_battleship_board.sv
// Self-checking bench for battleship_board with PC_DELAY = 4.
module tb_battleship_board;
  localparam int         NUM_SHIPS = 3;
  localparam logic [7:0] SEED      = 8'hA5;
  localparam int         PC_DELAY  = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [4:0][4:0][3:0] mp, mc;
  logic [2:0] game_state;
  logic player_won, pc_won;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  lfsr_m;
  logic [24:0] pc_ship_m, pl_ship_m, pl_shot_m, pc_shot_m;
  int          setup_edges;
  int          cur_r, cur_c;

  battleship_board #(.NUM_SHIPS(NUM_SHIPS), .SEED(SEED), .PC_DELAY(PC_DELAY)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel),
    .matriz_player_final(mp), .matriz_pc_final(mc),
    .game_state(game_state), .player_won(player_won), .pc_won(pc_won)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR running in lockstep with the design's free-running one.
  always @(posedge clk) lfsr_m <= !rst ? SEED : lfsr_step(lfsr_m);

  function automatic int idx(input int r, input int c);
    return r * 5 + c;
  endfunction

  function automatic bit cand_ok(input logic [7:0] v);
    return (v[2:0] < 3'd5) && (v[5:3] < 3'd5);
  endfunction

  function automatic int cand_cell(input logic [7:0] v);
    return idx(int'(v[2:0]), int'(v[5:3]));
  endfunction

  // PC placement from SEED: ship map and number of edges until SETUP_PLAYER.
  task automatic model_pc_setup(output logic [24:0] ships, output int edges);
    logic [7:0] v;
    int placed;
    v = SEED; placed = 0; ships = '0; edges = 0;
    while (placed < NUM_SHIPS && edges < 1000) begin
      edges++;
      if (cand_ok(v) && !ships[cand_cell(v)]) begin
        ships[cand_cell(v)] = 1'b1;
        placed++;
      end
      v = lfsr_step(v);
    end
  endtask

  // Cell the PC hits when the player fires in a cycle whose LFSR value is l.
  function automatic int predict_pc_shot(input logic [7:0] l, input logic [24:0] shot);
    logic [7:0] v;
    v = l;
    for (int k = 0; k < PC_DELAY + 1; k++) v = lfsr_step(v);
    for (int k = 0; k < 600; k++) begin
      if (cand_ok(v) && !shot[cand_cell(v)]) return cand_cell(v);
      v = lfsr_step(v);
    end
    return -1;
  endfunction

  task automatic press(input logic sel, input logic up, input logic down,
                       input logic left, input logic right);
    btn_sel = sel; btn_up = up; btn_down = down; btn_left = left; btn_right = right;
    @(negedge clk);
    btn_sel = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic move_to(input int r, input int c);
    while (cur_r > r) begin press(0, 1, 0, 0, 0); cur_r--; end
    while (cur_r < r) begin press(0, 0, 1, 0, 0); cur_r++; end
    while (cur_c > c) begin press(0, 0, 0, 1, 0); cur_c--; end
    while (cur_c < c) begin press(0, 0, 0, 0, 1); cur_c++; end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = (game_state === target);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (game_state === target);
    end
  endtask

  task automatic place_fleet();
    move_to(0, 4); press(1, 0, 0, 0, 0);
    move_to(2, 2); press(1, 0, 0, 0, 0);
    move_to(4, 0); press(1, 0, 0, 0, 0);
    cur_r = 0; cur_c = 0;
    pl_ship_m = '0;
    pl_ship_m[idx(0, 4)] = 1'b1; pl_ship_m[idx(2, 2)] = 1'b1; pl_ship_m[idx(4, 0)] = 1'b1;
  endtask

  task automatic restart_to_setup_player(output bit ok);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pl_shot_m = '0; pc_shot_m = '0; pl_ship_m = '0;
    cur_r = 0; cur_c = 0;
    wait_state(3'd1, 200, ok);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (mp !== '0) begin n_fail++; $display("FAIL reset_player_matrix: got %h, expected 0", mp); end
    n_checks++; if (mc !== '0) begin n_fail++; $display("FAIL reset_pc_matrix: got %h, expected 0", mc); end
    n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", game_state); end
    n_checks++; if (player_won !== 1'b0 || pc_won !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b%b, expected 00", player_won, pc_won);
    end
  endtask

  task automatic test_pc_placement();
    model_pc_setup(pc_ship_m, setup_edges);
    cur_r = 0; cur_c = 0;
    pl_shot_m = '0; pc_shot_m = '0;
    rst = 1'b1;
    repeat (setup_edges - 1) @(negedge clk);
    n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL setup_pc_early: got %0d, expected 0", game_state); end
    @(negedge clk);
    n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL setup_pc_done: got %0d, expected 1", game_state); end
    @(negedge clk);
    n_checks++; if (mc !== '0) begin n_fail++; $display("FAIL pc_ships_hidden: got %h, expected 0", mc); end
    n_checks++; if (mp[0][0] !== 4'd4) begin n_fail++; $display("FAIL setup_cursor_home: got %0d, expected 4", mp[0][0]); end
  endtask

  task automatic test_cursor_saturation();
    repeat (3) press(0, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (mp[0][0] !== 4'd4) begin n_fail++; $display("FAIL cursor_up_sat: got %0d, expected 4", mp[0][0]); end
    repeat (6) press(0, 0, 0, 0, 1);
    @(negedge clk);
    n_checks++; if (mp[0][4] !== 4'd4 || mp[0][0] !== 4'd0) begin
      n_fail++; $display("FAIL cursor_right_sat: got [0][4]=%0d [0][0]=%0d, expected 4 and 0", mp[0][4], mp[0][0]);
    end
    repeat (6) press(0, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++; if (mp[4][4] !== 4'd4) begin n_fail++; $display("FAIL cursor_down_sat: got %0d, expected 4", mp[4][4]); end
    repeat (4) press(0, 1, 0, 0, 0);
    cur_r = 0; cur_c = 4;
  endtask

  task automatic test_placement();
    int ones;
    move_to(0, 4);
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    move_to(2, 2);
    press(1, 0, 0, 0, 0);
    n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL repeat_sel_ignored: got %0d, expected 1", game_state); end
    move_to(4, 0);
    press(1, 0, 0, 0, 0);
    n_checks++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL placement_done: got %0d, expected 2", game_state); end
    cur_r = 0; cur_c = 0;
    pl_ship_m = '0;
    pl_ship_m[idx(0, 4)] = 1'b1; pl_ship_m[idx(2, 2)] = 1'b1; pl_ship_m[idx(4, 0)] = 1'b1;
    @(negedge clk);
    ones = 0;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) if (mp[r][c] === 4'd1) ones++;
    n_checks++; if (mp[0][4] !== 4'd1 || mp[2][2] !== 4'd1 || mp[4][0] !== 4'd1 || ones != 3) begin
      n_fail++; $display("FAIL player_ships: got [0][4]=%0d [2][2]=%0d [4][0]=%0d count=%0d, expected 1 1 1 count=3",
                         mp[0][4], mp[2][2], mp[4][0], ones);
    end
    n_checks++; if (mc[0][0] !== 4'd4) begin n_fail++; $display("FAIL turn_cursor_home: got %0d, expected 4", mc[0][0]); end
  endtask

  task automatic test_player_turn();
    int ship_i, water_i, pred;
    bit ok;
    ship_i = -1; water_i = -1;
    for (int k = 24; k >= 0; k--) if (pc_ship_m[k]) ship_i = k;
    for (int k = 24; k >= 5; k--) if (!pc_ship_m[k]) water_i = k;
    // Hit on a PC ship.
    move_to(ship_i / 5, ship_i % 5);
    pred = predict_pc_shot(lfsr_m, pl_shot_m);
    press(1, 0, 0, 0, 0);
    pc_shot_m[ship_i] = 1'b1;
    n_checks++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL hit_to_wait: got %0d, expected 3", game_state); end
    @(negedge clk);
    n_checks++; if (mc[ship_i/5][ship_i%5] !== 4'd3) begin
      n_fail++; $display("FAIL hit_cell: got %0d, expected 3", mc[ship_i/5][ship_i%5]);
    end
    repeat (2) @(negedge clk);
    n_checks++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL wait_length: got %0d, expected 3", game_state); end
    @(negedge clk);
    n_checks++; if (game_state !== 3'd4) begin n_fail++; $display("FAIL wait_to_shoot: got %0d, expected 4", game_state); end
    wait_state(3'd2, 300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pc_shot_return: got state %0d, expected 2", game_state); end
    @(negedge clk);
    n_checks++; if (mp[pred/5][pred%5] !== (pl_ship_m[pred] ? 4'd3 : 4'd2)) begin
      n_fail++; $display("FAIL pc_shot_cell: got %0d, expected %0d", mp[pred/5][pred%5], pl_ship_m[pred] ? 3 : 2);
    end
    pl_shot_m[pred] = 1'b1;
    // Miss on water, with sel and up in the same cycle.
    move_to(water_i / 5, water_i % 5);
    pred = predict_pc_shot(lfsr_m, pl_shot_m);
    press(1, 1, 0, 0, 0);
    pc_shot_m[water_i] = 1'b1;
    n_checks++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL miss_to_wait: got %0d, expected 3", game_state); end
    @(negedge clk);
    n_checks++; if (mc[water_i/5][water_i%5] !== 4'd2) begin
      n_fail++; $display("FAIL miss_cell: got %0d, expected 2", mc[water_i/5][water_i%5]);
    end
    wait_state(3'd2, 300, ok);
    @(negedge clk);
    n_checks++; if (!ok || mc[water_i/5][water_i%5] !== 4'd4 || mc[water_i/5 - 1][water_i%5] === 4'd4) begin
      n_fail++; $display("FAIL sel_over_up: got cursor-cell %0d above %0d, expected 4 and not 4",
                         mc[water_i/5][water_i%5], mc[water_i/5 - 1][water_i%5]);
    end
    pl_shot_m[pred] = 1'b1;
    // Re-firing an already shot cell does nothing.
    press(1, 0, 0, 0, 0);
    n_checks++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL refire_ignored: got %0d, expected 2", game_state); end
    @(negedge clk);
    n_checks++; if (mc[water_i/5][water_i%5] !== 4'd4) begin
      n_fail++; $display("FAIL refire_cell: got %0d, expected 4", mc[water_i/5][water_i%5]);
    end
  endtask

  task automatic test_reset_mid_game();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mp !== '0 || mc !== '0) begin n_fail++; $display("FAIL midreset_matrices: got %h %h, expected 0", mp, mc); end
    n_checks++; if (game_state !== 3'd0 || player_won !== 1'b0 || pc_won !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got %0d %b%b, expected 0 00", game_state, player_won, pc_won);
    end
  endtask

  task automatic test_win();
    bit ok;
    int hits, left;
    restart_to_setup_player(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL win_setup: got state %0d, expected 1", game_state); end
    place_fleet();
    left = NUM_SHIPS;
    for (int k = 0; k < 25; k++) begin
      if (pc_ship_m[k]) begin
        move_to(k / 5, k % 5);
        press(1, 0, 0, 0, 0);
        left--;
        if (left > 0) wait_state(3'd2, 300, ok);
      end
    end
    n_checks++; if (game_state !== 3'd5 || player_won !== 1'b1 || pc_won !== 1'b0) begin
      n_fail++; $display("FAIL win_state: got %0d %b%b, expected 5 10", game_state, player_won, pc_won);
    end
    press(1, 0, 1, 0, 0);
    @(negedge clk);
    hits = 0;
    for (int k = 0; k < 25; k++) if (pc_ship_m[k] && mc[k/5][k%5] === 4'd3) hits++;
    n_checks++; if (hits != NUM_SHIPS || game_state !== 3'd5) begin
      n_fail++; $display("FAIL win_board: got %0d hit cells state %0d, expected %0d and 5", hits, game_state, NUM_SHIPS);
    end
  endtask

  task automatic test_lose();
    bit ok;
    int w, p, d, hits;
    logic [7:0] l;
    restart_to_setup_player(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lose_setup: got state %0d, expected 1", game_state); end
    place_fleet();
    for (int t = 0; t < NUM_SHIPS; t++) begin
      w = -1;
      for (int k = 24; k >= 0; k--) if (!pc_ship_m[k] && !pc_shot_m[k]) w = k;
      move_to(w / 5, w % 5);
      // Delay the shot so the PC's answer lands on a still-unhit player ship.
      l = lfsr_m; d = -1; p = -1;
      for (int k = 0; k < 600 && d < 0; k++) begin
        p = predict_pc_shot(l, pl_shot_m);
        if (p >= 0 && pl_ship_m[p]) d = k;
        else l = lfsr_step(l);
      end
      if (d > 0) repeat (d) @(negedge clk);
      press(1, 0, 0, 0, 0);
      pc_shot_m[w] = 1'b1;
      if (p >= 0) pl_shot_m[p] = 1'b1;
      if (t < NUM_SHIPS - 1) begin
        wait_state(3'd2, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL lose_turn_%0d: got state %0d, expected 2", t, game_state); end
      end
    end
    wait_state(3'd6, 300, ok);
    n_checks++; if (!ok || pc_won !== 1'b1 || player_won !== 1'b0) begin
      n_fail++; $display("FAIL lose_state: got %0d %b%b, expected 6 01", game_state, player_won, pc_won);
    end
    press(1, 0, 0, 0, 0); press(0, 1, 0, 0, 0); press(1, 0, 1, 0, 1); press(0, 0, 0, 1, 0);
    @(negedge clk);
    hits = 0;
    for (int k = 0; k < 25; k++) if (pl_ship_m[k] && mp[k/5][k%5] === 4'd3) hits++;
    n_checks++; if (game_state !== 3'd6 || pc_won !== 1'b1 || hits != NUM_SHIPS) begin
      n_fail++; $display("FAIL lose_sticky: got state %0d pc_won %b hits %0d, expected 6 1 %0d",
                         game_state, pc_won, hits, NUM_SHIPS);
    end
    n_checks++; if (mc[w/5][w%5] !== 4'd2) begin
      n_fail++; $display("FAIL lose_pc_board: got %0d, expected 2", mc[w/5][w%5]);
    end
  endtask

  initial begin
    test_reset();
    test_pc_placement();
    test_cursor_saturation();
    test_placement();
    test_player_turn();
    test_reset_mid_game();
    test_win();
    test_lose();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/battleship_board.md
# battleship_board

Game-state engine for the 5x5 Battleship game. It places the PC fleet pseudo-randomly and lets the player place a fleet from a cursor and push-button pulses. It alternates player and PC shots and detects win/loss. It produces the two registered 5x5 display matrices, `matriz_player_final` and `matriz_pc_final`, that the VGA top consumes; it sits directly upstream of that block.

## Interface
- `NUM_SHIPS`, 3: single-cell ships per side; legal range 1..8.
- `SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `PC_DELAY`, 25_000_000: cycles the PC waits before each shot. Benches use 4.
- `clk`  in  1  system clock; same clock as the VGA top's `clk`.
- `rst`  in  1  synchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel`  in  1 each  debounced single-cycle pulses.
- `matriz_player_final`  out  [3:0] [4:0][4:0]  player board display codes, indexed [row][col].
- `matriz_pc_final`  out  [3:0] [4:0][4:0]  PC board display codes, indexed [row][col].
- `game_state`  out  3  current FSM state code.
- `player_won`, `pc_won`  out  1 each  sticky result flags.

## Operation
- Display codes:
  - 0: water, or an unhit PC ship (PC ships are always hidden).
  - 1: player's own ship.
  - 2: miss.
  - 3: hit.
  - 4: cursor. The cursor overlays the player board in SETUP_PLAYER and the PC board in PLAYER_TURN.
- Internal storage:
  - per board, a 25-bit ship map and a 25-bit shot map.
  - cursor row and cursor col, 3 bits each, range 0..4.
  - per side, a 4-bit hit counter.
  - an 8-bit PC-delay-independent LFSR and a delay counter.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left. It advances every cycle, including while waiting.
- Candidate cell: row = `lfsr[2:0]`, col = `lfsr[5:3]`. The candidate is valid only if both are < 5; otherwise retry on the next cycle.
- FSM, with codes 0..6:
  - SETUP_PC (0): each cycle, a valid candidate not already in the PC ship map gets a ship. After NUM_SHIPS placements, go to SETUP_PLAYER.
  - SETUP_PLAYER (1): direction pulses move the cursor, saturating at 0 and 4 (no wrap). `btn_sel` on an empty cell places a ship; `btn_sel` on an occupied cell is ignored. After NUM_SHIPS placements, the cursor resets to (0,0) and the FSM goes to PLAYER_TURN.
  - PLAYER_TURN (2): cursor moves as in SETUP_PLAYER. `btn_sel` on an unshot PC cell marks it shot; if that cell holds a ship, the player hit count increments. If the new hit count equals NUM_SHIPS, go to WIN; otherwise go to PC_WAIT. `btn_sel` on an already-shot cell is ignored.
  - PC_WAIT (3): count PC_DELAY cycles, then go to PC_SHOOT.
  - PC_SHOOT (4): retry until a valid candidate falls on an unshot player cell. Mark it shot and update the PC hit count. Go to LOSE if the PC hit count equals NUM_SHIPS; otherwise go to PLAYER_TURN.
  - WIN (5), LOSE (6): terminal states, left only by reset. All buttons are ignored.
- Button rules:
  - Buttons are ignored in states 0, 3, 4, 5 and 6.
  - If several pulses arrive in the same cycle, only one action is taken. Priority: sel > up > down > left > right.
- `player_won` = (state == WIN). `pc_won` = (state == LOSE).

## Timing
- Reset, sampled at a clk edge while `rst` = 0:
  - every matrix cell = 0.
  - cursor = (0,0); hit counts = 0; delay counter = 0.
  - `game_state` = 0; both result flags = 0.
  - LFSR = SEED.
- Reset asserted mid-game gives the same result in the next cycle. No partial state is kept.
- All outputs are registered. A pulse accepted at edge N changes internal state at edge N, and the display matrices reflect it at edge N+1.
- SETUP_PC lasts at least NUM_SHIPS cycles; the exact length is set by the LFSR sequence.
- In PC_WAIT, the PC shot lands exactly PC_DELAY+1 cycles after entry into PC_WAIT, plus any PC_SHOOT retry cycles.
- Cursor code 4 takes precedence over codes 0 through 3 in the display overlay.

## Test plan
- Reset: drive `rst` = 0 for 2 cycles -> all 50 cells = 0, `game_state` = 0, `player_won` = `pc_won` = 0. Reassert `rst` mid-PLAYER_TURN -> same values one cycle later.
- PC placement: SEED = 8'hA5 -> the bench's LFSR model predicts 3 PC ships; `game_state` reaches 1 in the predicted cycle; `matriz_pc_final` remains all 0 (ships hidden) apart from the cursor.
- Cursor saturation: in state 1, pulse `btn_up` ×3 -> cursor stays at (0,0). Pulse `btn_right` ×6 -> cursor at (0,4), and `matriz_player_final[0][4]` = 4.
- Placement: `btn_sel` at (0,4) twice, then at (2,2) and (4,0) -> only 3 ships placed (repeat ignored); those cells read 1; `game_state` = 2.
- Player turn:
  - fire on a model-predicted PC ship -> that cell reads 3 and `game_state` = 3.
  - fire on a water cell -> that cell reads 2.
  - `btn_sel` together with `btn_up` -> sel wins and the cursor does not move.
  - re-firing a shot cell -> no state change.
- Endgame, PC_DELAY = 4: hit all 3 PC ships -> `game_state` = 5, `player_won` = 1. Separate run where the PC sinks all 3 player ships first -> `game_state` = 6, `pc_won` = 1; any button input afterwards has no effect.
